// File: rtl/move_entry_ctrl_if.sv
// rtl/move_entry_ctrl_if.sv - key byte input and move handshake bundle for move_entry_ctrl
interface move_entry_ctrl_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic       move_ready;
  logic       move_valid;
  logic [3:0] move_letter;
  logic [3:0] move_number;
  logic       player_turn;
  logic       letter_shown;
  logic       number_shown;

  modport master (
    output key_valid, key_code, move_ready,
    input  move_valid, move_letter, move_number, player_turn, letter_shown, number_shown
  );

  modport slave (
    input  key_valid, key_code, move_ready,
    output move_valid, move_letter, move_number, player_turn, letter_shown, number_shown
  );
endinterface

// File: rtl/move_entry_ctrl.sv
// rtl/move_entry_ctrl.sv - PS/2 letter+digit move entry FSM with valid/ready move handshake
// Optional ENTRY_TIMEOUT_EN: discard a partial entry after TIMEOUT_CYCLES idle cycles.
module move_entry_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 135000000
) (
  input logic             clock27,
  input logic             reset,
  move_entry_ctrl_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, HAVE_L, HAVE_LN, SUBMIT} state_t;

  state_t     state;
  logic       brk_flag;
  logic       ext_flag;
  logic       is_prefix;
  logic       accept;
  logic       is_letter;
  logic       is_digit;
  logic       is_enter;
  logic       is_bksp;
  logic [3:0] code_letter;
  logic [3:0] code_digit;

  always_comb begin
    is_letter   = 1'b1;
    code_letter = 4'd0;
    case (bus.key_code)
      8'h1C: code_letter = 4'd0;
      8'h32: code_letter = 4'd1;
      8'h21: code_letter = 4'd2;
      8'h23: code_letter = 4'd3;
      8'h24: code_letter = 4'd4;
      8'h2B: code_letter = 4'd5;
      8'h34: code_letter = 4'd6;
      8'h33: code_letter = 4'd7;
      8'h43: code_letter = 4'd8;
      8'h3B: code_letter = 4'd9;
      default: is_letter = 1'b0;
    endcase
  end

  always_comb begin
    is_digit   = 1'b1;
    code_digit = 4'd0;
    case (bus.key_code)
      8'h45: code_digit = 4'd0;
      8'h16: code_digit = 4'd1;
      8'h1E: code_digit = 4'd2;
      8'h26: code_digit = 4'd3;
      8'h25: code_digit = 4'd4;
      8'h2E: code_digit = 4'd5;
      8'h36: code_digit = 4'd6;
      8'h3D: code_digit = 4'd7;
      8'h3E: code_digit = 4'd8;
      8'h46: code_digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

  // A byte following a break/extended prefix belongs to that sequence and is dropped.
  assign is_prefix = (bus.key_code == 8'hF0) || (bus.key_code == 8'hE0);
  assign accept    = bus.key_valid && !is_prefix && !brk_flag && !ext_flag;
  assign is_enter  = (bus.key_code == 8'h5A);
  assign is_bksp   = (bus.key_code == 8'h66);

`ifdef ENTRY_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        in_entry;
  logic        restart;
  logic        timeout_hit;

  assign in_entry    = (state == HAVE_L) || (state == HAVE_LN);
  assign restart     = accept && (((state == HAVE_L) && (is_letter || is_digit || is_bksp)) ||
                                  ((state == HAVE_LN) && (is_enter || is_bksp)));
  assign timeout_hit = in_entry && (idle_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clock27 or posedge reset) begin
    if (reset) begin
      idle_cnt <= 32'd0;
    end else if (!in_entry || restart || timeout_hit) begin
      idle_cnt <= 32'd0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`endif

  always_ff @(posedge clock27 or posedge reset) begin
    if (reset) begin
      state            <= EMPTY;
      brk_flag         <= 1'b0;
      ext_flag         <= 1'b0;
      bus.move_valid   <= 1'b0;
      bus.move_letter  <= 4'd0;
      bus.move_number  <= 4'd0;
      bus.player_turn  <= 1'b0;
      bus.letter_shown <= 1'b0;
      bus.number_shown <= 1'b0;
    end else begin
      if (bus.key_valid) begin
        if (bus.key_code == 8'hF0) begin
          brk_flag <= 1'b1;
        end else if (bus.key_code == 8'hE0) begin
          ext_flag <= 1'b1;
        end else begin
          brk_flag <= 1'b0;
          ext_flag <= 1'b0;
        end
      end

      case (state)
        EMPTY: begin
          if (accept && is_letter) begin
            bus.move_letter  <= code_letter;
            bus.letter_shown <= 1'b1;
            state            <= HAVE_L;
          end
        end
        HAVE_L: begin
          if (accept && is_letter) begin
            bus.move_letter <= code_letter;
          end else if (accept && is_digit) begin
            bus.move_number  <= code_digit;
            bus.number_shown <= 1'b1;
            state            <= HAVE_LN;
          end else if (accept && is_bksp) begin
            bus.move_letter  <= 4'd0;
            bus.letter_shown <= 1'b0;
            state            <= EMPTY;
          end
`ifdef ENTRY_TIMEOUT_EN
          else if (timeout_hit) begin
            bus.move_letter  <= 4'd0;
            bus.letter_shown <= 1'b0;
            state            <= EMPTY;
          end
`endif
        end
        HAVE_LN: begin
          if (accept && is_enter) begin
            bus.move_valid <= 1'b1;
            state          <= SUBMIT;
          end else if (accept && is_bksp) begin
            bus.move_number  <= 4'd0;
            bus.number_shown <= 1'b0;
            state            <= HAVE_L;
          end
`ifdef ENTRY_TIMEOUT_EN
          else if (timeout_hit) begin
            bus.move_letter  <= 4'd0;
            bus.move_number  <= 4'd0;
            bus.letter_shown <= 1'b0;
            bus.number_shown <= 1'b0;
            state            <= EMPTY;
          end
`endif
        end
        SUBMIT: begin
          // Keys are ignored while a move is pending, so the handshake always wins.
          if (bus.move_ready) begin
            bus.player_turn  <= ~bus.player_turn;
            bus.move_valid   <= 1'b0;
            bus.move_letter  <= 4'd0;
            bus.move_number  <= 4'd0;
            bus.letter_shown <= 1'b0;
            bus.number_shown <= 1'b0;
            state            <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_move_entry_ctrl.sv
// tb/tb_move_entry_ctrl.sv - randomized and directed self-checking bench for move_entry_ctrl
`timescale 1ns/1ps
module tb_move_entry_ctrl;

  localparam int TOUT = 100;

  logic clock27 = 1'b0;
  logic reset   = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  move_entry_ctrl_if bus ();

  move_entry_ctrl #(.TIMEOUT_CYCLES(TOUT)) dut (
    .clock27 (clock27),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 clock27 = ~clock27;

  logic [7:0] letter_codes [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
  logic [7:0] digit_codes  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // Reference: what the player has typed so far and whether a move is waiting.
  bit       m_lp, m_np, m_pend, m_turn, m_brk, m_ext;
  int       m_letter, m_num;
`ifdef ENTRY_TIMEOUT_EN
  int       m_idle;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [7:0] code, input logic [7:0] tbl [10]);
    for (int i = 0; i < 10; i++) if (tbl[i] == code) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_lp = 0; m_np = 0; m_pend = 0; m_turn = 0; m_brk = 0; m_ext = 0;
    m_letter = 0; m_num = 0;
`ifdef ENTRY_TIMEOUT_EN
    m_idle = 0;
`endif
  endtask

  task automatic model_step(input bit kv, input logic [7:0] kc, input bit mr);
    bit prefix, usable, acted, in_entry;
    int li, di;
    prefix   = (kc == 8'hF0) || (kc == 8'hE0);
    usable   = kv && !prefix && !m_brk && !m_ext;
    if (kv) begin
      if (kc == 8'hF0) m_brk = 1;
      else if (kc == 8'hE0) m_ext = 1;
      else begin m_brk = 0; m_ext = 0; end
    end
    li       = lookup(kc, letter_codes);
    di       = lookup(kc, digit_codes);
    acted    = 0;
    in_entry = m_lp && !m_pend;
    if (m_pend) begin
      if (mr) begin
        m_turn = !m_turn; m_pend = 0; m_lp = 0; m_np = 0; m_letter = 0; m_num = 0;
      end
    end else if (usable) begin
      if (!m_lp) begin
        if (li >= 0) begin m_lp = 1; m_letter = li; acted = 1; end
      end else if (!m_np) begin
        if (li >= 0) begin m_letter = li; acted = 1; end
        else if (di >= 0) begin m_np = 1; m_num = di; acted = 1; end
        else if (kc == 8'h66) begin m_lp = 0; m_letter = 0; acted = 1; end
      end else begin
        if (kc == 8'h5A) begin m_pend = 1; acted = 1; end
        else if (kc == 8'h66) begin m_np = 0; m_num = 0; acted = 1; end
      end
    end
`ifdef ENTRY_TIMEOUT_EN
    if (in_entry && !acted) begin
      if (m_idle == TOUT - 1) begin
        m_lp = 0; m_np = 0; m_letter = 0; m_num = 0; m_idle = 0;
      end else begin
        m_idle++;
      end
    end else begin
      m_idle = 0;
    end
`else
    if (in_entry && acted) m_idle_unused();
`endif
  endtask

`ifndef ENTRY_TIMEOUT_EN
  function automatic void m_idle_unused();
  endfunction
`endif

  task automatic check_all(input string tag);
    check_eq({tag, ".valid"},  32'(bus.move_valid),   32'(m_pend));
    check_eq({tag, ".letter"}, 32'(bus.move_letter),  32'(m_letter));
    check_eq({tag, ".number"}, 32'(bus.move_number),  32'(m_num));
    check_eq({tag, ".turn"},   32'(bus.player_turn),  32'(m_turn));
    check_eq({tag, ".lshow"},  32'(bus.letter_shown), 32'(m_lp));
    check_eq({tag, ".nshow"},  32'(bus.number_shown), 32'(m_np));
  endtask

  task automatic cycle(input string tag, input bit kv, input logic [7:0] kc, input bit mr);
    bus.key_valid  = kv;
    bus.key_code   = kc;
    bus.move_ready = mr;
    @(posedge clock27);
    model_step(kv, kc, mr);
    #1;
    check_all(tag);
  endtask

  task automatic key(input string tag, input logic [7:0] kc);
    cycle(tag, 1'b1, kc, 1'b0);
  endtask

  task automatic do_reset();
    bus.key_valid = 0; bus.key_code = 8'h00; bus.move_ready = 0;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    @(posedge clock27); #3;
    reset = 1'b0;
    #1;
    check_all("rst_release");
  endtask

  initial begin
    logic [7:0] codes [4] = '{8'h21, 8'h1C, 8'h16, 8'h5A};
    bus.key_valid = 0; bus.key_code = 8'h00; bus.move_ready = 0;
    model_reset();
    #2;
    check_all("reset_state");
    #10;
    reset = 1'b0;

    // Basic submit and handshake.
    key("s1", 8'h1C); key("s1", 8'h16); key("s1", 8'h5A);
    check_eq("s1.valid_up", 32'(bus.move_valid), 32'd1);
    check_eq("s1.num", 32'(bus.move_number), 32'd1);
    cycle("s1hs", 1'b0, 8'h00, 1'b1);
    check_eq("s1.valid_down", 32'(bus.move_valid), 32'd0);
    check_eq("s1.turn", 32'(bus.player_turn), 32'd1);
    check_eq("s1.lshow", 32'(bus.letter_shown), 32'd0);

    // Break and extended sequences are filtered out.
    key("s2", 8'h1C); key("s2", 8'hF0); key("s2", 8'h1C); key("s2", 8'hE0);
    key("s2", 8'h16); key("s2", 8'h1E);
    check_eq("s2.letter", 32'(bus.move_letter), 32'd0);
    check_eq("s2.number", 32'(bus.move_number), 32'd2);
    do_reset();

    // Backspace, then a held pending move that ignores keys.
    key("s3", 8'h32); key("s3", 8'h16); key("s3", 8'h66); key("s3", 8'h26); key("s3", 8'h5A);
    for (int i = 0; i < 10; i++) cycle("s3hold", i == 4, 8'h21, 1'b0);
    check_eq("s3.valid", 32'(bus.move_valid), 32'd1);
    check_eq("s3.letter", 32'(bus.move_letter), 32'd1);
    check_eq("s3.number", 32'(bus.move_number), 32'd3);
    cycle("s3hs", 1'b1, 8'h1C, 1'b1);
    check_eq("s3.key_lost", 32'(bus.letter_shown), 32'd0);

    // Idle partial entry.
    key("s4", 8'h24);
    for (int i = 0; i < TOUT; i++) cycle("s4idle", 1'b0, 8'h00, 1'b0);
`ifdef ENTRY_TIMEOUT_EN
    check_eq("s4.timeout", 32'(bus.letter_shown), 32'd0);
`else
    check_eq("s4.persist", 32'(bus.letter_shown), 32'd1);
`endif

    // Reset in the middle of a pending move.
    key("s5", 8'h1C); key("s5", 8'h1E); key("s5", 8'h5A);
    bus.key_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    check_eq("s5.async_valid", 32'(bus.move_valid), 32'd0);
    check_eq("s5.async_lshow", 32'(bus.letter_shown), 32'd0);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      bit         kv;
      logic [7:0] kc;
      int         sel;
      kv  = ($urandom_range(0, 99) < 55);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    kc = letter_codes[$urandom_range(0, 9)];
        2, 3:    kc = digit_codes[$urandom_range(0, 9)];
        4, 5:    kc = 8'h5A;
        6:       kc = 8'h66;
        7:       kc = ($urandom_range(0, 1) == 0) ? 8'hF0 : 8'hE0;
        8:       kc = codes[$urandom_range(0, 3)];
        default: kc = 8'($urandom);
      endcase
      cycle("rnd", kv, kc, ($urandom_range(0, 99) < 25));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/move_entry_ctrl.md
MOVE_ENTRY_CTRL -- requirements
Module: move_entry_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 135000000, meaning idle cycles before a partial entry is discarded (5 s at 27 MHz; used only with ENTRY_TIMEOUT_EN).
REQ-002 The block SHALL have port clock27  input  1  sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port key_valid  input  1  one-cycle strobe per received PS/2 byte.
REQ-005 The block SHALL have port key_code  input  8  PS/2 set-2 byte, qualified by key_valid.
REQ-006 The block SHALL have port move_ready  input  1  game logic accepts the move.
REQ-007 The block SHALL have port move_valid  output  1  a complete move is offered.
REQ-008 The block SHALL have port move_letter  output  4  column index, A..J = 0..9.
REQ-009 The block SHALL have port move_number  output  4  row digit, 0..9.
REQ-010 The block SHALL have port player_turn  output  1  0 = player 1, 1 = player 2; drives the HEX player display.
REQ-011 The block SHALL have port letter_shown  output  1  letter display enable.
REQ-012 The block SHALL have port number_shown  output  1  number display enable.

Function
REQ-013 Byte filter SHALL work as follows: 0xF0 sets a break flag, 0xE0 sets an extended flag; the next byte with either flag set SHALL be discarded and both flags cleared; the prefix bytes themselves SHALL take no other action.
REQ-014 Codes SHALL be: letters A..J = 1C,32,21,23,24,2B,34,33,43,3B; digits 0..9 = 45,16,1E,26,25,2E,36,3D,3E,46; Enter = 5A; Backspace = 66; all other codes SHALL be ignored.
REQ-015 The FSM SHALL have states EMPTY, HAVE_L, HAVE_LN and SUBMIT.
REQ-016 In EMPTY: a letter SHALL latch move_letter, set letter_shown and go to HAVE_L; all other codes SHALL be ignored.
REQ-017 In HAVE_L: a letter SHALL replace move_letter; a digit SHALL latch move_number, set number_shown and go to HAVE_LN; Backspace SHALL clear letter_shown and move_letter and go to EMPTY.
REQ-018 In HAVE_LN: Enter SHALL go to SUBMIT; Backspace SHALL clear number_shown and move_number and go to HAVE_L; letters and digits SHALL be ignored.
REQ-019 In SUBMIT: move_valid SHALL be 1; move_letter, move_number and player_turn SHALL be held stable; key bytes SHALL be ignored, with the prefix flags still tracked.
REQ-020 On a rising edge in SUBMIT with move_ready=1: player_turn SHALL toggle, move_valid, letter_shown and number_shown SHALL clear, move_letter and move_number SHALL be set to 0, and the FSM SHALL go to EMPTY.
REQ-021 If a handshake and key_valid occur in the same cycle, the handshake SHALL win and the key SHALL be discarded.
REQ-022 All outputs SHALL be registered; a key sampled at edge n SHALL be visible after edge n; move_valid SHALL rise on the edge that samples Enter.
REQ-023 move_valid SHALL never deassert without a handshake or a reset.

Reset
REQ-024 Asserting reset SHALL immediately force EMPTY, clear both prefix flags, drive all outputs to 0 (player_turn=0, move_valid=0) and clear the timeout counter.
REQ-025 Reset during SUBMIT SHALL drop the pending move with no turn toggle.

Configuration
REQ-026 With ENTRY_TIMEOUT_EN defined: a counter SHALL run in HAVE_L/HAVE_LN, restart on each accepted letter, digit or Backspace, and on reaching TIMEOUT_CYCLES-1 SHALL force EMPTY and clear letter, number and both shown flags; the counter SHALL be held at 0 in EMPTY and SUBMIT.
REQ-027 Without ENTRY_TIMEOUT_EN: no counter SHALL be present and partial entries SHALL persist indefinitely.

Verification
REQ-028 Reset mid-run -> all outputs 0 asynchronously, before the next clock edge.
REQ-029 Bytes 1C,16,5A with move_ready=0 -> move_valid=1, letter 0, number 1, player_turn 0; then move_ready=1 -> next cycle move_valid=0, player_turn=1, shown flags 0.
REQ-030 Bytes 1C,F0,1C,E0,16,1E -> letter 0, number 2; break and extended bytes produce no change.
REQ-031 Bytes 32,16,66,26,5A -> move letter 1, number 3; hold move_ready=0 for 10 cycles -> move_valid and data stable; key byte 21 during this hold -> ignored.
REQ-032 ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=100: byte 24 then 100 idle cycles -> letter_shown=0, FSM in EMPTY; without the macro -> letter_shown remains 1.
